// File: rtl/apb_req_arbiter.sv
// Two-requester APB master: round-robin arbitration in front of a single
// SETUP/ACCESS sequencer with a bounded wait for pready.
module apb_req_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic        pclk,
   input  logic        presetn,
   input  logic [1:0]  req_valid,
   input  logic [1:0]  req_write,
   input  logic [31:0] req_addr0,
   input  logic [31:0] req_addr1,
   input  logic [7:0]  req_wdata0,
   input  logic [7:0]  req_wdata1,
   output logic [1:0]  req_ack,
   output logic [1:0]  req_done,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] paddr,
   output logic [7:0]  pwdata,
   output logic        pwrite,
   output logic        psel,
   output logic        penable,
   input  logic [7:0]  prdata,
   input  logic        pready,
   input  logic        pslverr
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t          state_reg;
   logic            ptr_reg;
   logic            gnt_reg;
   logic [CW-1:0]   wait_reg;
   logic            grant_next;
   logic [1:0]      gnt_onehot;

   // With both requesters pending the pointer decides; otherwise the lone one wins.
   always_comb begin
      grant_next = 1'b0;
      if (req_valid == 2'b11)
         grant_next = ptr_reg;
      else
         grant_next = req_valid[1];
   end

   assign gnt_onehot = gnt_reg ? 2'b10 : 2'b01;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_reg <= IDLE;
         ptr_reg   <= 1'b0;
         gnt_reg   <= 1'b0;
         wait_reg  <= '0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         pwrite    <= 1'b0;
         paddr     <= '0;
         pwdata    <= '0;
         req_ack   <= '0;
         req_done  <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         req_ack   <= '0;
         req_done  <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         case (state_reg)
            IDLE: begin
               psel    <= 1'b0;
               penable <= 1'b0;
               if (|req_valid) begin
                  gnt_reg   <= grant_next;
                  ptr_reg   <= ~grant_next;
                  req_ack   <= grant_next ? 2'b10 : 2'b01;
                  pwrite    <= req_write[grant_next];
                  paddr     <= grant_next ? req_addr1 : req_addr0;
                  pwdata    <= grant_next ? req_wdata1 : req_wdata0;
                  psel      <= 1'b1;
                  wait_reg  <= '0;
                  state_reg <= SETUP;
               end
            end
            SETUP: begin
               penable   <= 1'b1;
               state_reg <= ACCESS;
            end
            ACCESS: begin
               // pready is tested first so it beats a coincident timeout.
               if (pready) begin
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  req_done  <= gnt_onehot;
                  rsp_err   <= pslverr;
                  rsp_rdata <= pwrite ? 8'h00 : prdata;
                  state_reg <= IDLE;
               end else if (wait_reg == WAIT_LAST) begin
                  psel      <= 1'b0;
                  penable   <= 1'b0;
                  req_done  <= gnt_onehot;
                  rsp_err   <= 1'b1;
                  state_reg <= IDLE;
               end else begin
                  wait_reg <= wait_reg + CW'(1);
               end
            end
            default: begin
               psel      <= 1'b0;
               penable   <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed scenarios then random transfers checked
// against a transaction-level model (grant rule, completer memory, timeout).
module tb_apb_req_arbiter;

   localparam int TIMEOUT = 4;

   logic        pclk = 1'b0;
   logic        presetn;
   logic [1:0]  req_valid;
   logic [1:0]  req_write;
   logic [31:0] req_addr0, req_addr1;
   logic [7:0]  req_wdata0, req_wdata1;
   logic [1:0]  req_ack, req_done;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic [31:0] paddr;
   logic [7:0]  pwdata;
   logic        pwrite, psel, penable;
   logic [7:0]  prdata;
   logic        pready, pslverr;

   int checks = 0;
   int errors = 0;

   bit         model_ptr;
   int         prev_grant;
   logic [7:0] mem [logic [31:0]];

   apb_req_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .pclk(pclk), .presetn(presetn),
      .req_valid(req_valid), .req_write(req_write),
      .req_addr0(req_addr0), .req_addr1(req_addr1),
      .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
      .req_ack(req_ack), .req_done(req_done),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
      .psel(psel), .penable(penable),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 pclk = ~pclk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] mem_rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 8'h00;
   endfunction

   // One full transfer, entered and left at a falling edge with the DUT idle.
   task automatic xfer(input logic [1:0] v, input logic [1:0] wr,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input int waits, input logic serr, input bit hold_valid,
                       input string tag);
      int g, n_acc;
      bit tmo;
      logic [31:0] ea;
      logic [7:0] ed, exp_rd;
      logic ew;
      req_valid = v; req_write = wr;
      req_addr0 = a0; req_addr1 = a1; req_wdata0 = d0; req_wdata1 = d1;
      check({tag, ":idle_psel"}, {31'd0, psel}, 32'd0);
      g = (v == 2'b11) ? int'(model_ptr) : (v[1] ? 1 : 0);
      model_ptr = (g == 0);
      ea = (g == 1) ? a1 : a0;
      ed = (g == 1) ? d1 : d0;
      ew = wr[g];
      tmo = (waits >= TIMEOUT);
      n_acc = tmo ? TIMEOUT : waits + 1;
      exp_rd = (ew || tmo) ? 8'h00 : mem_rd(ea);
      @(negedge pclk);
      check({tag, ":ack"}, {30'd0, req_ack}, (g == 1) ? 32'd2 : 32'd1);
      check({tag, ":setup"}, {30'd0, psel, penable}, 32'd2);
      check({tag, ":paddr"}, paddr, ea);
      check({tag, ":pwrite_pwdata"}, {23'd0, pwrite, pwdata}, {23'd0, ew, ed});
      if (!hold_valid) req_valid = 2'b00;
      // Post-ack command churn must not reach the bus.
      if (g == 1) begin req_addr1 = $urandom; req_wdata1 = 8'($urandom); end
      else        begin req_addr0 = $urandom; req_wdata0 = 8'($urandom); end
      req_write = 2'($urandom);
      @(negedge pclk);
      for (int j = 0; j < n_acc; j++) begin
         check({tag, ":access"}, {27'd0, psel, penable, req_ack, rsp_err}, 32'h18);
         check({tag, ":access_hold"}, paddr ^ {24'd0, pwdata}, ea ^ {24'd0, ed});
         check({tag, ":no_done"}, {22'd0, req_done, rsp_rdata}, 32'd0);
         pready  = (j == waits);
         pslverr = (j == waits) ? serr : 1'($urandom);
         prdata  = (j == waits && !ew) ? mem_rd(ea) : 8'($urandom);
         @(negedge pclk);
      end
      pready = 1'b0; pslverr = 1'b0; prdata = 8'($urandom);
      check({tag, ":done"}, {30'd0, req_done}, (g == 1) ? 32'd2 : 32'd1);
      check({tag, ":rsp_err"}, {31'd0, rsp_err}, {31'd0, (tmo ? 1'b1 : serr)});
      check({tag, ":rsp_rdata"}, {24'd0, rsp_rdata}, {24'd0, exp_rd});
      check({tag, ":idle_after"}, {28'd0, psel, penable, req_ack}, 32'd0);
      if (ew && !tmo && !serr) mem[ea] = ed;
      prev_grant = g;
      $display("xfer %s grant=%0d write=%0b addr=%08h wdata=%02h waits=%0d tmo=%0b err=%0b rdata=%02h",
               tag, g, ew, ea, ed, waits, tmo, rsp_err, rsp_rdata);
   endtask

   initial begin
      int pg;
      presetn = 1'b0; req_valid = '0; req_write = '0;
      req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
      prdata = '0; pready = 1'b0; pslverr = 1'b0;
      model_ptr = 1'b0; prev_grant = -1;
      repeat (3) @(negedge pclk);
      check("reset_ctrl", {27'd0, psel, penable, pwrite, rsp_err, 1'b0}, 32'd0);
      check("reset_bus", paddr | {24'd0, pwdata}, 32'd0);
      check("reset_rsp", {20'd0, req_ack, req_done, rsp_rdata}, 32'd0);
      presetn = 1'b1;
      @(negedge pclk);

      xfer(2'b01, 2'b01, 32'd3, 32'd0, 8'hA5, 8'h00, 0, 1'b0, 1'b0, "wr0_a5");
      xfer(2'b01, 2'b00, 32'd3, 32'd0, 8'h00, 8'h00, 0, 1'b0, 1'b0, "rd0_a5");
      xfer(2'b10, 2'b10, 32'd0, 32'd20, 8'h00, 8'h3C, 1, 1'b1, 1'b0, "wr1_slverr");
      for (int k = 0; k < 4; k++) begin
         pg = prev_grant;
         xfer(2'b11, 2'b11, 32'(100 + k), 32'(200 + k), 8'(k), 8'(16 + k), k % 2, 1'b0, 1'b1, "rr_both");
         check("rr_order", prev_grant, k % 2);
         check("rr_no_repeat", {31'd0, (prev_grant == pg)}, 32'd0);
      end
      xfer(2'b10, 2'b00, 32'd0, 32'd20, 8'h00, 8'h00, 12, 1'b0, 1'b0, "timeout");
      xfer(2'b01, 2'b00, 32'd3, 32'd0, 8'h00, 8'h00, TIMEOUT - 1, 1'b0, 1'b0, "ready_at_limit");

      // Reset in ACCESS: grant 0 first so the pointer is left at 1.
      xfer(2'b01, 2'b01, 32'd7, 32'd0, 8'h77, 8'h00, 0, 1'b0, 1'b0, "pre_reset");
      req_valid = 2'b01; req_write = 2'b01; req_addr0 = 32'd9; req_wdata0 = 8'h99;
      @(negedge pclk);
      req_valid = 2'b00;
      @(negedge pclk);
      check("rst_in_access", {30'd0, psel, penable}, 32'd3);
      #2 presetn = 1'b0;
      #1;
      check("rst_immediate", {26'd0, psel, penable, req_done, req_ack}, 32'd0);
      model_ptr = 1'b0;
      @(negedge pclk);
      check("rst_hold", {26'd0, psel, penable, req_done, req_ack}, 32'd0);
      presetn = 1'b1;
      @(negedge pclk);
      check("rst_no_done", {28'd0, req_done, psel, penable}, 32'd0);
      xfer(2'b11, 2'b00, 32'd7, 32'd20, 8'h00, 8'h00, 0, 1'b0, 1'b0, "post_reset_dual");
      check("post_reset_grant0", prev_grant, 0);

      for (int k = 0; k < 40; k++) begin
         xfer(2'($urandom_range(1, 3)), 2'($urandom),
              32'($urandom_range(0, 7)), 32'($urandom_range(0, 7)),
              8'($urandom), 8'($urandom),
              int'($urandom_range(0, 5)), ($urandom_range(0, 3) == 0),
              1'($urandom), "rand");
      end
      req_valid = 2'b00;
      @(negedge pclk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, max ACCESS-phase cycles to wait for pready before aborting.
REQ-002 pclk  input  1  APB clock; all state updates on rising edge.
REQ-003 presetn  input  1  asynchronous active-low reset.
REQ-004 req_valid  input  2  per-requester command valid; bit i = requester i.
REQ-005 req_write  input  2  per-requester direction, 1 = write.
REQ-006 req_addr0, req_addr1  input  32 each  per-requester target address.
REQ-007 req_wdata0, req_wdata1  input  8 each  per-requester write data.
REQ-008 req_ack  output  2  one-hot one-cycle pulse: command of requester i accepted.
REQ-009 req_done  output  2  one-hot one-cycle pulse: transfer of requester i complete.
REQ-010 rsp_rdata  output  8  read data, valid while req_done is nonzero.
REQ-011 rsp_err  output  1  error flag, valid while req_done is nonzero.
REQ-012 paddr  output  32, pwdata  output  8, pwrite  output  1, psel  output  1, penable  output  1  APB master request signals.
REQ-013 prdata  input  8, pready  input  1, pslverr  input  1  APB completer response signals.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SETUP and ACCESS. All outputs SHALL be registered.
REQ-015 IDLE: psel=0, penable=0. If any req_valid bit is set, select one requester (REQ-016), latch its write/addr/wdata, pulse its req_ack bit for that cycle, and go to SETUP.
REQ-016 Arbitration SHALL be round-robin with a 1-bit priority pointer (reset 0).
- When both requesters are valid, the pointed requester wins.
- When only one is valid, it wins regardless of the pointer.
- After every grant, the pointer SHALL be set to the non-granted index.
REQ-017 SETUP: psel=1, penable=0, with paddr/pwrite/pwdata driven from the latched command. Unconditionally go to ACCESS next cycle.
REQ-018 ACCESS: psel=1, penable=1, with address, data and direction held stable. Stay in ACCESS while pready=0.
REQ-019 ACCESS with pready=1:
- Go to IDLE and pulse req_done for the granted requester in the following cycle.
- rsp_err = pslverr sampled on that edge.
- rsp_rdata = prdata for reads; rsp_rdata = 8'h00 for writes.
REQ-020 A wait counter SHALL clear on SETUP entry and increment each ACCESS cycle with pready=0.
- When it reaches TIMEOUT, go to IDLE and pulse req_done with rsp_err=1 and rsp_rdata=8'h00.
- A pready arriving on the same edge as the timeout SHALL win (normal completion).
REQ-021 Minimum transfer is 3 cycles (SETUP, ACCESS, IDLE). The block SHALL issue no back-to-back transfer without an intervening IDLE cycle.
REQ-022 A requester SHALL hold req_valid and its command until its req_ack. Deasserting req_valid before ack withdraws the request with no side effects.
REQ-023 req_valid changes after ack SHALL NOT affect the in-flight transfer. A requester re-requesting while in flight SHALL be arbitrated at the next IDLE.
REQ-024 req_ack and req_done SHALL never have more than one bit set, and SHALL never be asserted in the same cycle.
REQ-025 When req_done is zero, rsp_rdata and rsp_err SHALL be 0.

Reset
REQ-026 presetn=0 SHALL immediately force:
- state to IDLE;
- psel, penable, pwrite to 0; paddr to 0; pwdata to 0;
- req_ack, req_done to 0; rsp_rdata, rsp_err to 0;
- wait counter and priority pointer to 0.
REQ-027 Reset mid-transfer SHALL abort the transfer with no req_done pulse. After presetn rises, the first arbitration SHALL favour requester 0.

Verification
REQ-028 Requester 0 writes addr 3, data 8'hA5; completer pready=1 in first ACCESS cycle -> req_ack=01, SETUP/ACCESS visible on the bus, req_done=01, rsp_err=0, 4 cycles from valid to done.
REQ-029 Requester 0 reads back addr 3 -> req_done=01, rsp_rdata=8'hA5, rsp_err=0.
REQ-030 Both requesters valid continuously with writes -> grants alternate 0,1,0,1; no requester is granted twice in a row.
REQ-031 Requester 1 writes addr 20 and completer returns pslverr=1 -> req_done=10, rsp_err=1, rsp_rdata=8'h00.
REQ-032 pready held 0 with TIMEOUT=4 -> exactly 4 ACCESS cycles, then IDLE, req_done pulse with rsp_err=1, psel=0.
REQ-033 presetn asserted during ACCESS -> psel=penable=0 immediately, no req_done. The next dual request is granted to requester 0.
